axi_mem_rd: RTL and testbench

AXI_MEM_RD -- requirements
Module: axi_mem_rd

---
 rtl/axi_mem_pkg.sv | 17 +
 rtl/axi_mem_rd_if.sv | 32 +++
 rtl/axi_mem_rd_fifo.sv | 49 ++++
 rtl/axi_mem_rd.sv | 135 +++++++++++++
 tb/tb_axi_mem_rd.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI4 read-only memory bridge: burst kinds, response code, FSM states.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/axi_mem_rd_if.sv
// AXI4 read address + read data channels; slave modport faces the memory bridge.
interface axi_mem_rd_if #(
  parameter int G_MEMWIDTH      = 32,
  parameter int G_IDWIDTH       = 4,
  parameter int G_AXI_ADDRWIDTH = 32
);

  logic                       s_arvalid;
  logic                       s_arready;
  logic [G_IDWIDTH-1:0]       s_arid;
  logic [G_AXI_ADDRWIDTH-1:0] s_araddr;
  logic [7:0]                 s_arlen;
  logic [1:0]                 s_arburst;

  logic                       s_rvalid;
  logic                       s_rready;
  logic [G_IDWIDTH-1:0]       s_rid;
  logic [G_MEMWIDTH-1:0]      s_rdata;
  logic [1:0]                 s_rresp;
  logic                       s_rlast;

  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arburst, s_rready,
    output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arburst, s_rready,
    input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
  );

endinterface

// File: rtl/axi_mem_rd_fifo.sv
// Two-entry first-word-fall-through FIFO; the head entry is a register driving the outputs.
module axi_mem_rd_fifo #(
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              vld,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] skid_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= skid_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: head_q <= (count_q == 2'd2) ? skid_q : din;
        default: ;
      endcase
    end
  end

  // Second slot only fills when the head is already occupied after this edge
  always_ff @(posedge clk) begin
    if (push && ((count_q == 2'd1 && !pop) || (count_q == 2'd2 && pop)))
      skid_q <= din;
  end

  assign dout  = head_q;
  assign vld   = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/axi_mem_rd.sv
// AXI4 read slave in front of a 1-cycle-latency memory port. WRAP bursts are
// honoured only when AXI_MEM_RD_WRAP_EN is defined; otherwise they run as INCR.
module axi_mem_rd
  import axi_mem_pkg::*;
#(
  parameter int G_MEMWIDTH      = 32,
  parameter int G_MEMDEPTH      = 1024,
  parameter int G_IDWIDTH       = 4,
  parameter int G_AXI_ADDRWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  axi_mem_rd_if.slave                   axi,
  output logic                          enb,
  output logic [$clog2(G_MEMDEPTH)-1:0] addrb,
  input  logic [G_MEMWIDTH-1:0]         doutb
);

  localparam int AW      = $clog2(G_MEMDEPTH);
  localparam int BYTE_SH = $clog2(G_MEMWIDTH / 8);
  localparam int ENTRY_W = G_IDWIDTH + 1 + G_MEMWIDTH;

  function automatic logic [AW-1:0] word_addr(input logic [G_AXI_ADDRWIDTH-1:0] byte_addr);
    logic [G_AXI_ADDRWIDTH-1:0] w;
    w = (byte_addr >> BYTE_SH) % G_AXI_ADDRWIDTH'(G_MEMDEPTH);
    return w[AW-1:0];
  endfunction

  function automatic burst_t decode_burst(input logic [1:0] raw);
    case (raw)
      2'b00: return BURST_FIXED;
`ifdef AXI_MEM_RD_WRAP_EN
      2'b10: return BURST_WRAP;
`endif
      default: return BURST_INCR;
    endcase
  endfunction

  state_t               state;
  logic [AW-1:0]        addr;
  logic [AW-1:0]        addr_next;
  logic [7:0]           beat;
  logic [7:0]           len;
  burst_t               burst;
  logic [G_IDWIDTH-1:0] id;

  logic                 vld_p1;
  logic                 last_p1;
  logic [G_IDWIDTH-1:0] id_p1;

  logic                 ar_hs;
  logic                 issue;
  logic                 pop;
  logic [2:0]           occ;
  logic                 fifo_vld;
  logic [1:0]           fifo_count;
  logic [ENTRY_W-1:0]   fifo_dout;

  assign axi.s_arready = (state == ST_IDLE) && !rst;
  assign ar_hs         = axi.s_arvalid && axi.s_arready;
  assign pop           = fifo_vld && axi.s_rready;

  // A slot freed by this cycle's hand-off counts as free, so a steady stream has no bubbles
  assign occ   = {2'b0, vld_p1} + {1'b0, fifo_count} - {2'b0, pop};
  assign issue = (state == ST_BURST) && !rst && (occ < 3'd2);

  assign enb   = issue;
  assign addrb = addr;

  always_comb begin
    addr_next = (addr == AW'(G_MEMDEPTH - 1)) ? '0 : addr + 1'b1;
    if (burst == BURST_FIXED) addr_next = addr;
`ifdef AXI_MEM_RD_WRAP_EN
    if (burst == BURST_WRAP)
      addr_next = (addr & ~AW'(len)) | ((addr + 1'b1) & AW'(len));
`endif
  end

  // stage p0: burst sequencing and memory read issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      beat   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            state <= ST_BURST;
            addr  <= word_addr(axi.s_araddr);
            beat  <= '0;
          end
        end
        default: begin
          if (issue) begin
            addr <= addr_next;
            beat <= beat + 8'd1;
            if (beat == len) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      len   <= axi.s_arlen;
      burst <= decode_burst(axi.s_arburst);
      id    <= axi.s_arid;
    end
    last_p1 <= (beat == len);
    id_p1   <= id;
  end

  // stage p1: memory data returns and is queued with its tags
  axi_mem_rd_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   ({id_p1, last_p1, doutb}),
    .pop   (pop),
    .dout  (fifo_dout),
    .vld   (fifo_vld),
    .count (fifo_count)
  );

  assign axi.s_rvalid = fifo_vld;
  assign {axi.s_rid, axi.s_rlast, axi.s_rdata} = fifo_dout;
  assign axi.s_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_rd.sv
// Randomised + directed bench for axi_mem_rd against a queue-based beat model.
module tb_axi_mem_rd;

  localparam int MW    = 32;
  localparam int DEPTH = 1024;
  localparam int IDW   = 4;
  localparam int ADW   = 32;

  typedef struct {
    logic [MW-1:0]  data;
    logic [IDW-1:0] id;
    logic           last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic enb;
  logic [$clog2(DEPTH)-1:0] addrb;
  logic [MW-1:0] doutb = '0;
  logic [MW-1:0] mem [DEPTH];

  axi_mem_rd_if #(.G_MEMWIDTH(MW), .G_IDWIDTH(IDW), .G_AXI_ADDRWIDTH(ADW)) axi ();

  axi_mem_rd #(
    .G_MEMWIDTH      (MW),
    .G_MEMDEPTH      (DEPTH),
    .G_IDWIDTH       (IDW),
    .G_AXI_ADDRWIDTH (ADW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .axi   (axi),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = MW'(i);
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rmode = 0;
  int    issued = 0;
  int    consumed = 0;
  int    hs_cnt = 0;
  int    first_hs = 0;
  int    last_hs = 0;
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: the word addresses a burst visits, computed directly from the burst rules
  task automatic model_burst(input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                             input logic [7:0] len, input logic [1:0] bt);
    int w, n, a, kind;
    beat_t b;
    w    = int'((addr / (MW / 8)) % DEPTH);
    n    = int'(len) + 1;
    kind = (bt == 2'b11) ? 1 : int'(bt);
`ifndef AXI_MEM_RD_WRAP_EN
    if (kind == 2) kind = 1;
`endif
    for (int i = 0; i < n; i++) begin
      if (kind == 0)      a = w;
      else if (kind == 2) a = (w - (w % n)) + ((w % n) + i) % n;
      else                a = (w + i) % DEPTH;
      b.data = MW'(a);
      b.id   = id;
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  initial begin : rready_drv
    axi.s_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       axi.s_rready = 1'b1;
        1:       axi.s_rready = ~axi.s_rready;
        default: axi.s_rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    logic hs;
    logic stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        issued     = 0;
        consumed   = 0;
        stall_prev = 1'b0;
      end else begin
        hs = axi.s_rvalid && axi.s_rready;
        if (stall_prev) chk("rvalid_hold", axi.s_rvalid, 1);
        if (axi.s_rvalid) begin
          if (exp_q.size() == 0) chk("spurious_rvalid", axi.s_rvalid, 0);
          else begin
            chk("rdata", axi.s_rdata, exp_q[0].data);
            chk("rid",   axi.s_rid,   exp_q[0].id);
            chk("rlast", axi.s_rlast, exp_q[0].last);
            chk("rresp", axi.s_rresp, 2'b00);
          end
        end
        if (enb) begin
          chk("outstanding", ((issued - consumed - int'(hs)) < 2), 1);
          issued++;
        end
        if (hs) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          consumed++;
          hs_cnt++;
          if (hs_cnt == 1) first_hs = cyc;
          last_hs = cyc;
        end
        stall_prev = axi.s_rvalid && !axi.s_rready;
      end
    end
  end

  task automatic ar(input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                    input logic [7:0] len, input logic [1:0] bt, input bit chk_lat);
    int n;
    @(posedge clk);
    #1;
    axi.s_arvalid = 1'b1;
    axi.s_arid    = id;
    axi.s_araddr  = addr;
    axi.s_arlen   = len;
    axi.s_arburst = bt;
    n = 0;
    @(negedge clk);
    while (!axi.s_arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!axi.s_arready) begin
      chk("ar_timeout", axi.s_arready, 1);
      axi.s_arvalid = 1'b0;
    end else begin
      model_burst(id, addr, len, bt);
      @(posedge clk);
      #1;
      axi.s_arvalid = 1'b0;
      if (chk_lat) begin
        @(negedge clk);
        @(negedge clk);
        chk("lat_early", axi.s_rvalid, 0);
        @(negedge clk);
        chk("lat_first", axi.s_rvalid, 1);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 80000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, n;
    logic [1:0] bt;
    logic [7:0] len;
    rst           = 1'b1;
    axi.s_arvalid = 1'b0;
    axi.s_arid    = '0;
    axi.s_araddr  = '0;
    axi.s_arlen   = '0;
    axi.s_arburst = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid",  axi.s_rvalid,  0);
    chk("rst_arready", axi.s_arready, 0);
    chk("rst_enb",     enb,           0);
    chk("rst_addrb",   addrb,         0);
    chk("rst_rdata",   axi.s_rdata,   0);
    chk("rst_rid",     axi.s_rid,     0);
    chk("rst_rlast",   axi.s_rlast,   0);
    chk("rst_rresp",   axi.s_rresp,   0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", axi.s_arready, 1);
    chk("post_rst_rvalid",  axi.s_rvalid,  0);

    // INCR 0x10 len 3, streaming
    rmode  = 0;
    hs_cnt = 0;
    ar(4'd1, 32'h10, 8'd3, 2'b01, 1'b1);
    drain();
    chk("incr_beats",  hs_cnt, 4);
    chk("incr_consec", last_hs - first_hs, 3);

    ar(4'd2, 32'h20, 8'd2, 2'b00, 1'b0);
    drain();

    rmode = 1;
    ar(4'd3, 32'h10, 8'd3, 2'b01, 1'b0);
    drain();

    rmode = 0;
    ar(4'd4, 32'h18, 8'd3, 2'b10, 1'b0);
    drain();

    ar(4'd5, 32'(1022 * 4), 8'd3, 2'b01, 1'b0);
    drain();

    // Back-to-back random bursts under random back-pressure
    rmode = 2;
    for (int k = 0; k < 30; k++) begin
      bt  = 2'($urandom_range(0, 3));
      len = 8'($urandom_range(0, 15));
`ifdef AXI_MEM_RD_WRAP_EN
      if (bt == 2'b10) len = 8'((2 << $urandom_range(0, 3)) - 1);
`endif
      ar(4'($urandom), $urandom, len, bt, 1'b0);
    end
    drain();

    // Reset in the middle of a long burst
    rmode = 0;
    base  = consumed;
    ar(4'd6, 32'h0, 8'd7, 2'b01, 1'b0);
    n = 0;
    while (consumed - base < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_beats", consumed - base >= 2, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_rvalid",  axi.s_rvalid,  0);
    chk("mid_rst_enb",     enb,           0);
    chk("mid_rst_arready", axi.s_arready, 0);
    chk("mid_rst_rlast",   axi.s_rlast,   0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_rvalid",  axi.s_rvalid,  0);
    chk("after_rst_arready", axi.s_arready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("stale_rvalid", axi.s_rvalid, 0);
    end
    hs_cnt = 0;
    ar(4'd7, 32'h0, 8'd0, 2'b01, 1'b1);
    drain();
    chk("single_beats", hs_cnt, 1);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
